// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: vsync-paced animation offsets and a 4-scene layer FSM.
// Optional SEQ_SKIP_EN: a sticky skip request advances the scene at the next tick.
module demo_scene_sequencer #(
  parameter int OFFSET_W     = 10,
  parameter int OFFSET_MAX   = 200,
  parameter int SCENE_FRAMES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                pause,
  input  logic [1:0]          step_sel,
  input  logic                skip,
  output logic [OFFSET_W-1:0] offset0,
  output logic [OFFSET_W-1:0] offset1,
  output logic [OFFSET_W-1:0] offset2,
  output logic [1:0]          scene,
  output logic                box_en,
  output logic                bmp_en,
  output logic                frame_tick,
  output logic                scene_change
);

  localparam int XW = OFFSET_W + 1;
  localparam int CW = $clog2(SCENE_FRAMES);

  typedef enum logic [1:0] {
    BOXES = 2'd0,
    TEXT  = 2'd1,
    MIX   = 2'd2,
    HOLD  = 2'd3
  } scene_e;

  scene_e              scene_q, scene_d;
  logic [CW-1:0]       frame_cnt_q;
  logic                vsync_d_q;
  logic                tick_q;
  logic                chg_q;
  logic                box_q, bmp_q;
  logic                box_d, bmp_d;
  logic [OFFSET_W-1:0] off_q [3];
  logic [OFFSET_W-1:0] off_d [3];
  logic                up_q  [3];
  logic                up_d  [3];
  logic [XW-1:0]       sum_x [3];
  logic [XW-1:0]       step_x;
  logic                move;
  logic                expire;
  logic                advance;
  logic                skip_now;

`ifdef SEQ_SKIP_EN
  logic skip_req_q;

  assign skip_now = skip_req_q | skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_req_q <= 1'b0;
    end else begin
      skip_req_q <= tick_q ? 1'b0 : skip_now;
    end
  end
`else
  logic unused_skip;

  assign unused_skip = skip;
  assign skip_now    = 1'b0;
`endif

  assign step_x  = XW'(step_sel) + XW'(1);
  assign move    = tick_q & ~pause & (scene_q != HOLD);
  assign expire  = ~pause & (frame_cnt_q == CW'(SCENE_FRAMES - 1));
  assign advance = tick_q & (expire | skip_now);
  assign scene_d = scene_e'(scene_q + 2'd1);

  always_comb begin
    box_d = 1'b1;
    bmp_d = 1'b1;
    unique case (1'b1)
      (scene_d == BOXES): bmp_d = 1'b0;
      (scene_d == TEXT):  box_d = 1'b0;
      default: ;
    endcase
  end

  // Bounce arithmetic is one bit wider so the sum cannot wrap past OFFSET_MAX.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      off_d[i] = off_q[i];
      up_d[i]  = up_q[i];
      sum_x[i] = {1'b0, off_q[i]} + step_x;
      if (move) begin
        if (up_q[i]) begin
          if (sum_x[i] >= XW'(OFFSET_MAX)) begin
            off_d[i] = OFFSET_W'(OFFSET_MAX);
            up_d[i]  = 1'b0;
          end else begin
            off_d[i] = sum_x[i][OFFSET_W-1:0];
          end
        end else if ({1'b0, off_q[i]} <= step_x) begin
          off_d[i] = '0;
          up_d[i]  = 1'b1;
        end else begin
          off_d[i] = off_q[i] - step_x[OFFSET_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_q   <= 1'b0;
      tick_q      <= 1'b0;
      chg_q       <= 1'b0;
      scene_q     <= BOXES;
      frame_cnt_q <= '0;
      box_q       <= 1'b1;
      bmp_q       <= 1'b0;
      off_q[0]    <= '0;
      off_q[1]    <= OFFSET_W'(100);
      off_q[2]    <= '0;
      up_q[0]     <= 1'b1;
      up_q[1]     <= 1'b0;
      up_q[2]     <= 1'b1;
    end else begin
      vsync_d_q <= vsync;
      tick_q    <= vsync & ~vsync_d_q;
      chg_q     <= advance;
      if (advance) begin
        scene_q     <= scene_d;
        frame_cnt_q <= '0;
        box_q       <= box_d;
        bmp_q       <= bmp_d;
      end else if (tick_q && !pause) begin
        frame_cnt_q <= frame_cnt_q + CW'(1);
      end
      for (int i = 0; i < 3; i++) begin
        off_q[i] <= off_d[i];
        up_q[i]  <= up_d[i];
      end
    end
  end

  assign offset0      = off_q[0];
  assign offset1      = off_q[1];
  assign offset2      = off_q[2];
  assign scene        = scene_q;
  assign box_en       = box_q;
  assign bmp_en       = bmp_q;
  assign frame_tick   = tick_q;
  assign scene_change = chg_q;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Bench for demo_scene_sequencer: behavioural frame model feeds a scoreboard.
// Built with SCENE_FRAMES=4 so scene wrap is reachable quickly.
module tb_demo_scene_sequencer;

  localparam int OW  = 10;
  localparam int OMX = 200;
  localparam int SF  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    step_sel = 2'd0;
  logic          skip = 1'b0;
  logic [OW-1:0] offset0, offset1, offset2;
  logic [1:0]    scene;
  logic          box_en, bmp_en, frame_tick, scene_change;

  demo_scene_sequencer #(
    .OFFSET_W(OW), .OFFSET_MAX(OMX), .SCENE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause),
    .step_sel(step_sel), .skip(skip),
    .offset0(offset0), .offset1(offset1), .offset2(offset2),
    .scene(scene), .box_en(box_en), .bmp_en(bmp_en),
    .frame_tick(frame_tick), .scene_change(scene_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o0, o1, o2, sc, box, bmp, chg;
  } exp_t;

  exp_t exq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ticks_seen = 0;
  int   chg_seen = 0;

  int m_off [3];
  int m_up  [3];
  int m_scene, m_cnt, m_skip;

  task automatic model_reset();
    m_off[0] = 0;   m_up[0] = 1;
    m_off[1] = 100; m_up[1] = 0;
    m_off[2] = 0;   m_up[2] = 1;
    m_scene = 0; m_cnt = 0; m_skip = 0;
  endtask

  task automatic model_tick(input int p, input int ss);
    int s;
    bit adv;
    s = ss + 1;
    adv = (m_skip != 0) || (p == 0 && m_cnt == SF - 1);
    if (p == 0 && m_scene != 3) begin
      for (int i = 0; i < 3; i++) begin
        if (m_up[i] != 0) begin
          if (m_off[i] + s >= OMX) begin m_off[i] = OMX; m_up[i] = 0; end
          else m_off[i] = m_off[i] + s;
        end else begin
          if (m_off[i] <= s) begin m_off[i] = 0; m_up[i] = 1; end
          else m_off[i] = m_off[i] - s;
        end
      end
    end
    if (adv) begin m_scene = (m_scene + 1) % 4; m_cnt = 0; end
    else if (p == 0) m_cnt = m_cnt + 1;
    m_skip = 0;
  endtask

  function automatic exp_t model_snap(input int chg);
    exp_t e;
    e.o0 = m_off[0]; e.o1 = m_off[1]; e.o2 = m_off[2];
    e.sc = m_scene;
    e.box = (m_scene != 1) ? 1 : 0;
    e.bmp = (m_scene != 0) ? 1 : 0;
    e.chg = chg;
    return e;
  endfunction

  task automatic do_frame(input int p, input int ss);
    exp_t e;
    int   sc0;
    bit   seen;
    @(negedge clk);
    pause = p[0]; step_sel = 2'(ss); skip = 1'b0; vsync = 1'b1;
    sc0 = m_scene;
    model_tick(p, ss);
    exq.push_back(model_snap((m_scene != sc0) ? 1 : 0));
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    n_tests++;
    e = exq.pop_front();
    if (!seen) begin
      n_fail++;
      $display("FAIL tick_timeout: frame_tick=%b required 1 within 6 cycles", frame_tick);
    end else begin
      ticks_seen++;
      @(negedge clk);
      if (scene_change === 1'b1) chg_seen++;
      if (offset0 !== OW'(e.o0) || offset1 !== OW'(e.o1) ||
          offset2 !== OW'(e.o2) || scene !== 2'(e.sc) ||
          box_en !== 1'(e.box) || bmp_en !== 1'(e.bmp) ||
          scene_change !== 1'(e.chg) || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL frame: got off=%0d/%0d/%0d sc=%0d box=%b bmp=%b chg=%b tick=%b, required off=%0d/%0d/%0d sc=%0d box=%0d bmp=%0d chg=%0d tick=0",
                 offset0, offset1, offset2, scene, box_en, bmp_en, scene_change, frame_tick,
                 e.o0, e.o1, e.o2, e.sc, e.box, e.bmp, e.chg);
      end
      vsync = 1'b0;
      @(negedge clk);
      n_tests++;
      if (scene_change !== 1'b0 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_width: chg=%b tick=%b required 0/0", scene_change, frame_tick);
      end
    end
    vsync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; skip = 1'b0; step_sel = 2'd0;
    model_reset();
    exq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit tick_any;
    do_reset();
    tick_any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (frame_tick !== 1'b0) tick_any = 1'b1;
    end
    n_tests++;
    if (offset0 !== 10'd0 || offset1 !== 10'd100 || offset2 !== 10'd0 ||
        scene !== 2'd0 || box_en !== 1'b1 || bmp_en !== 1'b0 ||
        scene_change !== 1'b0 || tick_any) begin
      n_fail++;
      $display("FAIL reset_state: off=%0d/%0d/%0d sc=%0d box=%b bmp=%b chg=%b tick_seen=%b, required 0/100/0 0 1 0 0 0",
               offset0, offset1, offset2, scene, box_en, bmp_en, scene_change, tick_any);
    end
  endtask

  task automatic test_scenes();
    int t0, c0;
    do_reset();
    t0 = ticks_seen; c0 = chg_seen;
    repeat (4) do_frame(0, 0);
    n_tests++;
    if (scene !== 2'd1 || box_en !== 1'b0 || bmp_en !== 1'b1 || chg_seen - c0 != 1) begin
      n_fail++;
      $display("FAIL scene_after4: sc=%0d box=%b bmp=%b chg_pulses=%0d, required 1 0 1 1",
               scene, box_en, bmp_en, chg_seen - c0);
    end
    do_frame(0, 0);
    n_tests++;
    if (offset0 !== 10'd5 || offset1 !== 10'd95 || offset2 !== 10'd5 || ticks_seen - t0 != 5) begin
      n_fail++;
      $display("FAIL five_ticks: off=%0d/%0d/%0d ticks=%0d, required 5/95/5 ticks=5",
               offset0, offset1, offset2, ticks_seen - t0);
    end
    repeat (11) do_frame(0, 0);
    n_tests++;
    if (scene !== 2'd0 || offset0 !== 10'd12 || offset1 !== 10'd88 || chg_seen - c0 != 4) begin
      n_fail++;
      $display("FAIL scene_wrap_hold: sc=%0d off0=%0d off1=%0d chg_pulses=%0d, required 0 12 88 4",
               scene, offset0, offset1, chg_seen - c0);
    end
  endtask

  task automatic skip_hold();
    for (int g = 0; g < 8 && m_scene == 3; g++) do_frame(0, 0);
  endtask

  task automatic test_bounce();
    int d, s, guard;
    do_reset();
    guard = 0;
    while (!(m_off[1] == 3 && m_up[1] == 0) && guard < 300) begin
      d = m_off[1] - 3;
      s = (m_up[1] == 0 && d > 0) ? ((d > 4) ? 4 : d) : 4;
      do_frame(0, s - 1);
      guard++;
    end
    skip_hold();
    do_frame(0, 3);
    n_tests++;
    if (offset1 !== 10'd0) begin
      n_fail++;
      $display("FAIL bounce_low: offset1=%0d required 0", offset1);
    end
    guard = 0;
    while (!(m_off[0] == 196 && m_up[0] == 1) && guard < 400) begin
      d = 196 - m_off[0];
      s = (m_up[0] == 1 && d > 0) ? ((d > 4) ? 4 : d) : 4;
      do_frame(0, s - 1);
      guard++;
    end
    skip_hold();
    do_frame(0, 3);
    n_tests++;
    if (offset0 !== 10'd200) begin
      n_fail++;
      $display("FAIL bounce_high: offset0=%0d required 200", offset0);
    end
    skip_hold();
    do_frame(0, 3);
    n_tests++;
    if (offset0 !== 10'd196) begin
      n_fail++;
      $display("FAIL bounce_return: offset0=%0d required 196", offset0);
    end
  endtask

  task automatic test_midframe();
    exp_t e;
    do_frame(0, 1);
    e = model_snap(0);
    repeat (2) @(negedge clk);
    step_sel = 2'd3; pause = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (offset0 !== OW'(e.o0) || offset1 !== OW'(e.o1) || scene !== 2'(e.sc) || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_stable: off=%0d/%0d sc=%0d tick=%b, required %0d/%0d %0d 0",
               offset0, offset1, scene, frame_tick, e.o0, e.o1, e.sc);
    end
    do_frame(0, 0);
  endtask

  task automatic test_pause();
    exp_t e;
    int t0;
    skip_hold();
    e = model_snap(0);
    t0 = ticks_seen;
    repeat (10) do_frame(1, 2);
    n_tests++;
    if (ticks_seen - t0 != 10 || offset0 !== OW'(e.o0) || offset1 !== OW'(e.o1) ||
        offset2 !== OW'(e.o2) || scene !== 2'(e.sc)) begin
      n_fail++;
      $display("FAIL pause_freeze: ticks=%0d off=%0d/%0d/%0d sc=%0d, required 10 %0d/%0d/%0d %0d",
               ticks_seen - t0, offset0, offset1, offset2, scene, e.o0, e.o1, e.o2, e.sc);
    end
  endtask

  task automatic test_skip();
    int want;
    @(negedge clk);
    pause = 1'b1; skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
`ifdef SEQ_SKIP_EN
    m_skip = 1;
    want = (m_scene + 1) % 4;
`else
    want = m_scene;
`endif
    repeat (3) @(negedge clk);
    do_frame(1, 0);
    n_tests++;
    if (scene !== 2'(want)) begin
      n_fail++;
      $display("FAIL skip_scene: scene=%0d required %0d", scene, want);
    end
    do_frame(0, 0);
  endtask

  task automatic test_reset_midframe();
    bit tick_any;
    do_frame(0, 2);
    do_frame(0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (offset0 !== 10'd0 || offset1 !== 10'd100 || offset2 !== 10'd0 ||
        scene !== 2'd0 || box_en !== 1'b1 || bmp_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: off=%0d/%0d/%0d sc=%0d box=%b bmp=%b, required 0/100/0 0 1 0",
               offset0, offset1, offset2, scene, box_en, bmp_en);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick_any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (frame_tick !== 1'b0) tick_any = 1'b1;
    end
    n_tests++;
    if (tick_any) begin
      n_fail++;
      $display("FAIL tick_after_reset: frame_tick seen=1 required 0 without vsync edge");
    end
    do_frame(0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scenes();
    test_bounce();
    test_midframe();
    test_pause();
    test_skip();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
